// File: rtl/alu_pkg.sv
// Types shared by the ALU command issuer and the combinational ALU it drives.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_LSR, OP_AND, OP_OR, OP_XOR, OP_EQL
  } op_e;

  typedef enum logic [1:0] {
    IDLE, EXEC, HOLD
  } issuer_state_e;

endpackage

// File: rtl/alu_cmd_issuer.sv
// Issues commands to an external combinational ALU and returns each result over a
// valid/ready port, with an accumulator that lets a command reuse the previous result.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int                CNT_W   = 16,
  parameter logic [DATA_W-1:0] ACC_RST = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  input  logic [2:0]        cmd_op_i,
  input  logic              cmd_acc_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [2:0]        alu_op_o,
  input  logic [DATA_W-1:0] alu_res_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic [2:0]        res_op_o,
  output logic [DATA_W-1:0] acc_o,
  output logic [CNT_W-1:0]  done_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  issuer_state_e     state;
  logic              cmd_fire;
  logic              res_fire;
  logic [DATA_W-1:0] a_sel;

  // In HOLD a new command is only taken when the pending result leaves in the same
  // cycle, so ready follows the consumer combinationally there.
  assign cmd_ready_o = (state == IDLE) || ((state == HOLD) && res_ready_i);
  assign cmd_fire    = cmd_valid_i & cmd_ready_o;
  assign res_fire    = res_valid_o & res_ready_i;
  assign a_sel       = cmd_acc_i ? acc_o : cmd_a_i;

  // NOTE: every register here is written with <= so all of them sample the values
  // from before the edge; blocking writes would let later lines see updated state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      alu_a_o     <= '0;
      alu_b_o     <= '0;
      alu_op_o    <= '0;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_op_o    <= '0;
      acc_o       <= ACC_RST;
      done_cnt_o  <= '0;
    end else begin
      // A command can only fire in IDLE or in HOLD alongside the result handshake.
      if (cmd_fire) begin
        alu_a_o  <= a_sel;
        alu_b_o  <= cmd_b_i;
        alu_op_o <= cmd_op_i;
      end

      case (state)
        IDLE: begin
          if (cmd_fire) state <= EXEC;
        end
        EXEC: begin
          res_data_o  <= alu_res_i;
          res_op_o    <= alu_op_o;
          acc_o       <= alu_res_i;
          res_valid_o <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (res_fire) begin
            res_valid_o <= 1'b0;
            if (done_cnt_o != '1) done_cnt_o <= done_cnt_o + CNT_ONE;
            state <= cmd_fire ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: issuer plus a behavioural ALU, checked against a
// transaction-level model; a second instance with CNT_W=2 checks counter saturation.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam logic [7:0] ACC_RST_TB = 8'h3C;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       acc;
    logic [7:0] res;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] op;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_acc, res_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] cmd_op;

  logic        cmd_ready, res_valid;
  logic [7:0]  alu_a, alu_b, alu_res, res_data, acc;
  logic [2:0]  alu_op, res_op;
  logic [15:0] done_cnt;

  logic       cmd_ready_s, res_valid_s;
  logic [7:0] alu_a_s, alu_b_s, alu_res_s, res_data_s, acc_s;
  logic [2:0] alu_op_s, res_op_s;
  logic [1:0] done_cnt_s;

  int         total = 0;
  int         bad = 0;
  logic [7:0] model_acc;
  int         model_cnt;
  exp_t       exp_q[$];
  vec_t       vecs[11];

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return (a >= b) ? a - b : b - a;
      OP_SLL:  return a << b[2:0];
      OP_LSR:  return a >> b[2:0];
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return (a == b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  assign alu_res   = alu_f(alu_a, alu_b, alu_op);
  assign alu_res_s = alu_f(alu_a_s, alu_b_s, alu_op_s);

  alu_cmd_issuer #(.CNT_W(16), .ACC_RST(ACC_RST_TB)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_op_i(cmd_op), .cmd_acc_i(cmd_acc),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_res_i(alu_res),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_op_o(res_op),
    .acc_o(acc), .done_cnt_o(done_cnt)
  );

  alu_cmd_issuer #(.CNT_W(2), .ACC_RST(ACC_RST_TB)) dut_s (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_s),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_op_i(cmd_op), .cmd_acc_i(cmd_acc),
    .alu_a_o(alu_a_s), .alu_b_o(alu_b_s), .alu_op_o(alu_op_s), .alu_res_i(alu_res_s),
    .res_valid_o(res_valid_s), .res_ready_i(res_ready),
    .res_data_o(res_data_s), .res_op_o(res_op_s),
    .acc_o(acc_s), .done_cnt_o(done_cnt_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    model_acc = ACC_RST_TB;
    model_cnt = 0;
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Present a command and hold it until the handshake edge; returns one step after it.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic acc_sel);
    int         n = 0;
    exp_t       e;
    logic [7:0] a_eff;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_acc   = acc_sel;
    #1;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_a     = 8'($urandom);
    cmd_b     = 8'($urandom);
    cmd_op    = 3'($urandom);
    cmd_acc   = 1'($urandom);
    a_eff     = acc_sel ? model_acc : a;
    e.d       = alu_f(a_eff, b, op);
    e.op      = op;
    model_acc = e.d;
    exp_q.push_back(e);
  endtask

  // Wait for the result, hold it back for 'delay' cycles, then consume it.
  task automatic take(input int delay);
    int   n = 0;
    exp_t e;
    while (!res_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!res_valid) begin
      check("res_valid_timeout", {31'd0, res_valid}, 32'd1);
      return;
    end
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("res_data", {24'd0, res_data}, {24'd0, e.d});
    check("res_op", {29'd0, res_op}, {29'd0, e.op});
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      check("stall_data", {24'd0, res_data}, {24'd0, e.d});
      check("stall_ready", {31'd0, cmd_ready}, 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    model_cnt++;
    check("done_cnt", {16'd0, done_cnt}, model_cnt);
    check("res_valid_drop", {31'd0, res_valid}, 32'd0);
    check("acc", {24'd0, acc}, {24'd0, model_acc});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b2b_exp[4];
    logic [7:0] a_eff;

    vecs[0]  = '{8'hF0, 8'h20, OP_ADD, 1'b0, 8'h10};
    vecs[1]  = '{8'h03, 8'h05, OP_SUB, 1'b0, 8'h02};
    vecs[2]  = '{8'h5A, 8'h5A, OP_EQL, 1'b0, 8'h01};
    vecs[3]  = '{8'h05, 8'h03, OP_ADD, 1'b0, 8'h08};
    vecs[4]  = '{8'hFF, 8'h02, OP_SLL, 1'b1, 8'h20};
    vecs[5]  = '{8'h80, 8'h0B, OP_LSR, 1'b0, 8'h10};
    vecs[6]  = '{8'h00, 8'h01, OP_SUB, 1'b1, 8'h0F};
    vecs[7]  = '{8'hC3, 8'h0F, OP_AND, 1'b0, 8'h03};
    vecs[8]  = '{8'h5A, 8'h5B, OP_EQL, 1'b0, 8'h00};
    vecs[9]  = '{8'hA0, 8'h05, OP_XOR, 1'b1, 8'h05};
    vecs[10] = '{8'h81, 8'h18, OP_OR,  1'b0, 8'h99};

    reset = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", {24'd0, res_data}, 32'd0);
    check("rst_res_op", {29'd0, res_op}, 32'd0);
    check("rst_alu_ops", {13'd0, alu_a, alu_b, alu_op}, 32'd0);
    check("rst_acc", {24'd0, acc}, {24'd0, ACC_RST_TB});
    check("rst_done_cnt", {16'd0, done_cnt}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Directed vectors, including latency and accumulator chaining.
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].acc);
      check("vec_lat_n1", {31'd0, res_valid}, 32'd0);
      @(posedge clk); #1;
      check("vec_lat_n2", {31'd0, res_valid}, 32'd1);
      check("vec_res", {24'd0, res_data}, {24'd0, vecs[i].res});
      check("vec_op", {29'd0, res_op}, {29'd0, vecs[i].op});
      take(0);
      check("vec_acc", {24'd0, acc}, {24'd0, vecs[i].res});
    end

    // Consumer stalls while a second command waits: nothing must be accepted.
    issue(8'h11, 8'h22, OP_OR, 1'b0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_a = 8'h77; cmd_b = 8'h01; cmd_op = OP_ADD; cmd_acc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, res_valid}, 32'd1);
      check("hold_data", {24'd0, res_data}, 32'h33);
      check("hold_ready", {31'd0, cmd_ready}, 32'd0);
      check("hold_alu_a", {24'd0, alu_a}, 32'h11);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    #1;
    check("hold_ready_pass", {31'd0, cmd_ready}, 32'd1);
    res_ready = 1'b0;
    take(0);

    // Four back-to-back commands with the consumer always ready.
    res_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("b2b_valid", {31'd0, res_valid},
            {31'd0, (c >= 2 && c <= 8 && (c % 2) == 0)});
      if (c >= 2 && c <= 8 && (c % 2) == 0)
        check("b2b_data", {24'd0, res_data}, {24'd0, b2b_exp[c/2-1]});
      if ((c % 2) == 0 && c <= 6) begin
        cmd_valid = 1'b1;
        cmd_a     = 8'($urandom);
        cmd_b     = 8'($urandom);
        cmd_op    = 3'($urandom);
        cmd_acc   = (c != 0) ? 1'($urandom) : 1'b0;
        a_eff     = cmd_acc ? model_acc : cmd_a;
        b2b_exp[c/2] = alu_f(a_eff, cmd_b, cmd_op);
        model_acc = b2b_exp[c/2];
      end else if (c == 8) begin
        cmd_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    res_ready = 1'b0;
    model_cnt += 4;
    check("b2b_done_cnt", {16'd0, done_cnt}, model_cnt);
    check("b2b_acc", {24'd0, acc}, {24'd0, model_acc});

    // Reset while the ALU result is being captured.
    issue(8'h12, 8'h34, OP_ADD, 1'b0);
    pulse_reset();
    check("rst_exec_valid", {31'd0, res_valid}, 32'd0);
    check("rst_exec_acc", {24'd0, acc}, {24'd0, ACC_RST_TB});
    check("rst_exec_cnt", {16'd0, done_cnt}, 32'd0);
    check("rst_exec_alu_a", {24'd0, alu_a}, 32'd0);

    // Reset while a result is waiting for the consumer.
    issue(8'h40, 8'h02, OP_LSR, 1'b0);
    take(0);
    issue(8'h0F, 8'h01, OP_SLL, 1'b0);
    @(posedge clk); #1;
    check("pre_rst_hold", {31'd0, res_valid}, 32'd1);
    pulse_reset();
    check("rst_hold_valid", {31'd0, res_valid}, 32'd0);
    check("rst_hold_acc", {24'd0, acc}, {24'd0, ACC_RST_TB});
    check("rst_hold_cnt", {16'd0, done_cnt}, 32'd0);
    check("rst_hold_ready", {31'd0, cmd_ready}, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      issue(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom));
      take(int'($urandom_range(0, 2)));
    end

    // Counter saturation on the narrow instance.
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      issue(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom));
      take(0);
      check("sat_cnt_small", {30'd0, done_cnt_s}, (model_cnt > 3) ? 3 : model_cnt);
    end
    check("sat_cnt_wide", {16'd0, done_cnt}, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
